// File: rtl/crc_check_slave.sv
// Bus-mapped CRC checker. It divides a written codeword bit-serially by the
// generator and exposes pass/fail, the syndrome and a saturating error count.
module crc_check_slave #(
  parameter int                   DATA_WIDTH     = 32,
  parameter int                   CRC_WIDTH      = 3,
  parameter logic [CRC_WIDTH-1:0] POLYNOMIAL     = 3'h3,
  parameter int                   COUNTER_WIDTH  = $clog2(DATA_WIDTH),
  parameter int                   LSB_DATA_WIDTH = DATA_WIDTH - CRC_WIDTH,
  parameter int                   ERRCNT_WIDTH   = 16
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  cs,
  input  logic [1:0]            addr,
  input  logic                  write,
  input  logic                  read,
  input  logic [DATA_WIDTH-1:0] write_data,
  output logic [DATA_WIDTH-1:0] read_data,
  output logic                  read_data_valid,
  output logic                  wait_req
);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_e;

  state_e                    state_q, state_d;
  logic [DATA_WIDTH-1:0]     codeword_q, codeword_d;
  logic [CRC_WIDTH-1:0]      rem_q, rem_d, rem_nxt;
  logic [COUNTER_WIDTH-1:0]  cnt_q, cnt_d;
  logic [CRC_WIDTH-1:0]      syn_q, syn_d;
  logic                      pass_q, pass_d, done_q, done_d;
  logic [ERRCNT_WIDTH-1:0]   errcnt_q, errcnt_d;
  logic [DATA_WIDTH-1:0]     rdata_q, rdata_d;
  logic                      rvld_q;
  logic                      start, clr, fail_entry, busy;

  assign busy  = (state_q == SHIFT);
  assign start = cs & write & (addr == 2'd0) & ~busy;
  assign clr   = cs & write & (addr == 2'd3);

  // One division step: shift in the next codeword bit, reduce on the bit shifted out.
  assign rem_nxt = {rem_q[CRC_WIDTH-2:0], codeword_q[cnt_q]} ^
                   (rem_q[CRC_WIDTH-1] ? POLYNOMIAL : '0);

  always_comb begin
    state_d    = state_q;
    codeword_d = codeword_q;
    rem_d      = rem_q;
    cnt_d      = cnt_q;
    syn_d      = syn_q;
    pass_d     = pass_q;
    done_d     = done_q;
    errcnt_d   = errcnt_q;
    rdata_d    = rdata_q;
    fail_entry = 1'b0;

    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          codeword_d = write_data;
          rem_d      = '0;
          cnt_d      = COUNTER_WIDTH'(DATA_WIDTH - 1);
          done_d     = 1'b0;
          state_d    = SHIFT;
        end
      end
      SHIFT: begin
        rem_d = rem_nxt;
        cnt_d = cnt_q - COUNTER_WIDTH'(1);
        if (cnt_q == '0) begin
          syn_d      = rem_nxt;
          pass_d     = (rem_nxt == '0);
          done_d     = 1'b1;
          fail_entry = (rem_nxt != '0);
          state_d    = DONE;
        end
      end
      default: state_d = IDLE;
    endcase

    // A failure landing on the same edge as a clear still counts once.
    if (clr) errcnt_d = '0;
    if (fail_entry) begin
      if (clr)                  errcnt_d = ERRCNT_WIDTH'(1);
      else if (errcnt_q != '1)  errcnt_d = errcnt_q + ERRCNT_WIDTH'(1);
    end

    if (cs & read) begin
      case (addr)
        2'd0:    rdata_d = codeword_q;
        2'd1:    rdata_d = {{(DATA_WIDTH-3){1'b0}}, done_q, busy, pass_q};
        2'd2:    rdata_d = DATA_WIDTH'(syn_q);
        default: rdata_d = DATA_WIDTH'(errcnt_q);
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      codeword_q <= '0;
      rem_q      <= '0;
      cnt_q      <= '0;
      syn_q      <= '0;
      pass_q     <= 1'b0;
      done_q     <= 1'b0;
      errcnt_q   <= '0;
      rdata_q    <= '0;
      rvld_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      codeword_q <= codeword_d;
      rem_q      <= rem_d;
      cnt_q      <= cnt_d;
      syn_q      <= syn_d;
      pass_q     <= pass_d;
      done_q     <= done_d;
      errcnt_q   <= errcnt_d;
      rdata_q    <= rdata_d;
      rvld_q     <= cs & read;
    end
  end

  assign read_data       = rdata_q;
  assign read_data_valid = rvld_q;
  assign wait_req        = busy;

endmodule

// File: tb/tb_crc_check_slave.sv
// Directed bench for crc_check_slave using hand-computed remainders mod x^3+x+1.
module tb_crc_check_slave;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        cs = 1'b0, write = 1'b0, read = 1'b0;
  logic [1:0]  addr = '0;
  logic [31:0] write_data = '0;
  logic [31:0] read_data;
  logic        read_data_valid, wait_req;

  int n_chk = 0;
  int n_fail = 0;

  crc_check_slave dut (
    .clk(clk), .reset_n(reset_n), .cs(cs), .addr(addr), .write(write),
    .read(read), .write_data(write_data), .read_data(read_data),
    .read_data_valid(read_data_valid), .wait_req(wait_req)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Called at a negedge; the write is taken on the following posedge.
  task automatic bus_wr(input logic [1:0] a, input logic [31:0] d);
    cs = 1'b1; write = 1'b1; addr = a; write_data = d;
    @(negedge clk);
    cs = 1'b0; write = 1'b0;
  endtask

  task automatic bus_rd(input string tag, input logic [1:0] a, input logic [31:0] exp);
    cs = 1'b1; read = 1'b1; addr = a;
    @(negedge clk);
    cs = 1'b0; read = 1'b0;
    chk({tag, "_vld"}, {31'd0, read_data_valid}, 32'd1);
    chk(tag, read_data, exp);
  endtask

  task automatic wait_idle(input string tag, output int cycles);
    cycles = 0;
    while (wait_req && cycles < 100) begin
      @(negedge clk);
      cycles++;
    end
    if (cycles >= 100) chk({tag, "_timeout"}, 32'd1, 32'd0);
  endtask

  task automatic run_check(input string tag, input logic [31:0] cw,
                           input logic [31:0] exp_stat, input logic [31:0] exp_syn,
                           input logic [31:0] exp_err);
    int cyc;
    bus_wr(2'd0, cw);
    wait_idle(tag, cyc);
    bus_rd({tag, "_stat"}, 2'd1, exp_stat);
    bus_rd({tag, "_syn"},  2'd2, exp_syn);
    bus_rd({tag, "_err"},  2'd3, exp_err);
  endtask

  initial begin
    int cyc;
    repeat (3) @(negedge clk);
    chk("rst_rdata", read_data, 32'd0);
    chk("rst_rvld", {31'd0, read_data_valid}, 32'd0);
    chk("rst_wait", {31'd0, wait_req}, 32'd0);
    reset_n = 1'b1;
    @(negedge clk);
    bus_rd("rst_stat", 2'd1, 32'd0);
    bus_rd("rst_cw", 2'd0, 32'd0);

    // 0xB = x^3+x+1 itself: divides exactly, 32 busy cycles.
    bus_wr(2'd0, 32'h0000_000B);
    wait_idle("b", cyc);
    chk("b_busy_cycles", cyc, 32'd32);
    bus_rd("b_stat", 2'd1, 32'd5);
    bus_rd("b_syn", 2'd2, 32'd0);
    bus_rd("b_err", 2'd3, 32'd0);
    bus_rd("b_cw", 2'd0, 32'h0000_000B);

    run_check("a",  32'h0000_000A, 32'd4, 32'd1, 32'd1);
    run_check("16", 32'h0000_0016, 32'd5, 32'd0, 32'd1);
    run_check("0",  32'h0000_0000, 32'd5, 32'd0, 32'd1);

    // Status while running keeps the previous pass: {done=0,busy=1,pass=1}.
    bus_wr(2'd0, 32'h0000_0009);
    bus_rd("run_stat", 2'd1, 32'd3);
    wait_idle("9", cyc);
    bus_rd("9_stat", 2'd1, 32'd4);
    bus_rd("9_syn", 2'd2, 32'd2);
    bus_rd("9_err", 2'd3, 32'd2);

    run_check("f", 32'h0000_000F, 32'd4, 32'd4, 32'd3);
    // x^31 mod g = x^3 = x+1 (g primitive, order 7).
    run_check("msb", 32'h8000_0000, 32'd4, 32'd3, 32'd4);

    // Start during SHIFT is dropped.
    bus_wr(2'd0, 32'h0000_000A);
    repeat (4) @(negedge clk);
    bus_wr(2'd0, 32'h0000_000B);
    wait_idle("ign", cyc);
    bus_rd("ign_cw", 2'd0, 32'h0000_000A);
    bus_rd("ign_syn", 2'd2, 32'd1);
    bus_rd("ign_err", 2'd3, 32'd5);

    // Clear landing on the failing DONE-entry edge (k+32) leaves 1.
    bus_wr(2'd0, 32'h0000_000A);
    repeat (31) @(negedge clk);
    bus_wr(2'd3, 32'h0);
    bus_rd("race_err", 2'd3, 32'd1);
    bus_wr(2'd3, 32'h1234);
    bus_rd("clr_err", 2'd3, 32'd0);

    // Back-to-back reads give back-to-back pulses, then none.
    cs = 1'b1; read = 1'b1; addr = 2'd1;
    @(negedge clk);
    chk("b2b_v0", {31'd0, read_data_valid}, 32'd1);
    chk("b2b_d0", read_data, 32'd4);
    addr = 2'd2;
    @(negedge clk);
    cs = 1'b0; read = 1'b0;
    chk("b2b_v1", {31'd0, read_data_valid}, 32'd1);
    chk("b2b_d1", read_data, 32'd1);
    @(negedge clk);
    chk("b2b_v2", {31'd0, read_data_valid}, 32'd0);

    // cs low masks read and write.
    read = 1'b1; write = 1'b1; addr = 2'd0; write_data = 32'h0000_000B;
    @(negedge clk);
    read = 1'b0; write = 1'b0;
    chk("nocs_vld", {31'd0, read_data_valid}, 32'd0);
    chk("nocs_wait", {31'd0, wait_req}, 32'd0);

    // Write+read together: new check starts, read returns old codeword.
    cs = 1'b1; write = 1'b1; read = 1'b1; addr = 2'd0; write_data = 32'h0000_000B;
    @(negedge clk);
    cs = 1'b0; write = 1'b0; read = 1'b0;
    chk("wr_rd_vld", {31'd0, read_data_valid}, 32'd1);
    chk("wr_rd_data", read_data, 32'h0000_000A);
    chk("wr_rd_wait", {31'd0, wait_req}, 32'd1);
    wait_idle("wr_rd", cyc);
    bus_rd("wr_rd_stat", 2'd1, 32'd5);

    // Reset at SHIFT cycle 10.
    bus_wr(2'd0, 32'h0000_000A);
    repeat (9) @(negedge clk);
    reset_n = 1'b0;
    #1;
    chk("arst_wait", {31'd0, wait_req}, 32'd0);
    chk("arst_rdata", read_data, 32'd0);
    chk("arst_rvld", {31'd0, read_data_valid}, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    bus_rd("arst_cw", 2'd0, 32'd0);
    bus_rd("arst_stat", 2'd1, 32'd0);
    bus_rd("arst_syn", 2'd2, 32'd0);
    bus_rd("arst_err", 2'd3, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
